polar_decoder_ctrl: RTL and testbench
=====================================

# polar_decoder_ctrl

Top-level sequencing FSM for the successive-cancellation polar decoder. It drives the one-hot `state` bus consumed by the LLR calculator and maintains the decoded-bit index `id_counter_value`. It runs four phases in order: channel-LLR loading into the init BRAM, per-bit LLR read/compute iterations, partial-sum update handshakes, and streaming of the decoded block out of the output buffer.

## Interface
Parameters:
- `N`, 1024: code length; decoded bits per frame.
- `ADDR_WIDTH`, 10: BRAM address width, equal to log2(N).
- `ID_COUNTER_WIDTH`, 10: width of the bit index, equal to log2(N).
- `DATA_WIDTH`, 8: LLR word width.
- `STATE_WIDTH`, 9: one-hot state bus width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: frame start request; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at frame end.
- `in_valid` in 1: channel-LLR input is valid.
- `in_data` in DATA_WIDTH: channel-LLR input word.
- `in_ready` out 1: high in INPUT.
- `addr_to_llr_init_bram_wr` out ADDR_WIDTH: write address for the init BRAM.
- `data_to_llr_init_bram_wr` out DATA_WIDTH: equals `in_data`.
- `write_enable_to_llr_init_bram` out 1: equals `in_valid & in_ready`.
- `state` out STATE_WIDTH: one-hot state to the LLR calculator.
- `llr_sigle_bit_fin` in 1: from the calculator; current bit's layer-0 result is being computed.
- `llr_cal_fin` in 1: from the calculator; last bit (index N-1) is finishing.
- `id_counter_value` out ID_COUNTER_WIDTH: current decoded-bit index.
- `ps_start` out 1: one-cycle pulse requesting a partial-sum update.
- `ps_done` in 1: partial-sum unit completion, one-cycle pulse.
- `addr_to_out_buffer_bram` out ADDR_WIDTH: output-buffer read address.
- `enable_to_out_buffer_bram` out 1: output-buffer read enable; high in OUTPUT.
- `data_from_out_buffer_bram` in 1: output-buffer read data, 1-cycle read latency.
- `out_valid` out 1: decoded-bit output is valid.
- `out_data` out 1: decoded bit; equals `data_from_out_buffer_bram`.
- `out_ready` in 1: downstream accepts the output bit.

## Operation
One-hot state encodings:
- IDLE = 9'd1
- INPUT = 9'd2
- LLR_READ = 9'd4
- LLR_CAL_AND_STORE = 9'd8
- PS_UPDATE = 9'd16
- OUTPUT = 9'd32
- DONE = 9'd64
- Bits 8 and 7 are never set. Any illegal encoding is treated as IDLE on the next edge.

State behaviour:
- **IDLE**
  - `start`=1 → INPUT. Clears the input counter, `id_counter_value`, the output counter and `primed`.
  - `start` outside IDLE is ignored.
- **INPUT**
  - `in_ready`=1. Each `in_valid`=1 cycle writes `in_data` to address `in_cnt`, then increments `in_cnt`.
  - A handshake with `in_cnt`=N-1 → LLR_READ.
  - `in_valid` may drop at any time; no timeout.
- **LLR_READ**
  - Always one cycle → LLR_CAL_AND_STORE. Covers the BRAM read latency.
- **LLR_CAL_AND_STORE**
  - `llr_sigle_bit_fin`=0 → LLR_READ (next layer).
  - `llr_sigle_bit_fin`=1 and `llr_cal_fin`=1 → OUTPUT.
  - `llr_sigle_bit_fin`=1 and `llr_cal_fin`=0 → PS_UPDATE, with `ps_start` pulsed in the first PS_UPDATE cycle.
- **PS_UPDATE**
  - Waits for `ps_done`. On `ps_done`=1: `id_counter_value` += 1, then → LLR_READ.
  - A `ps_done` arriving in the same cycle as `ps_start` is accepted.
  - `ps_done` outside PS_UPDATE is ignored.
- **OUTPUT**
  - `fire` = `out_valid & out_ready`.
  - `addr_to_out_buffer_bram` = `fire` ? `out_cnt`+1 : `out_cnt`.
  - `primed` is set one cycle after entry; `out_valid` = `primed`.
  - On `fire`: `out_cnt` += 1.
  - `fire` with `out_cnt`=N-1 → DONE.
  - With `out_ready` low, the address and the data are held.
- **DONE**
  - `done`=1 for one cycle → IDLE.

Width rules:
- All counters are ADDR_WIDTH bits wide and wrap naturally.
- Terminal compares use N-1, so there is no overflow when N = 2^ADDR_WIDTH.

## Timing
- Reset values: state=IDLE, so `state`=9'd1.
- All other outputs reset to 0: `busy`, `done`, `in_ready`, `write_enable_to_llr_init_bram`, `ps_start`, `out_valid`, `enable_to_out_buffer_bram`, all addresses, `id_counter_value`.
- `reset_n` low mid-frame aborts immediately; outputs return to reset values asynchronously. After deassertion, a new `start` is required.
- Registered outputs: `state`, `id_counter_value`, counters, `ps_start`, `done`, `primed`.
- Combinational decodes of state/counters: `busy`, `in_ready`, `out_valid`, write enable, read enable, addresses.
- `start` to first `in_ready`: 1 cycle.
- Last input handshake to first LLR_READ: 1 cycle.
- Each layer iteration costs 2 cycles (LLR_READ + LLR_CAL_AND_STORE).
- PS_UPDATE costs ≥1 cycle. `ps_start` is never re-pulsed while waiting.
- First `out_valid`: 2 cycles after the final LLR_CAL_AND_STORE.
- Output throughput: 1 bit/cycle while `out_ready`=1.
- `done`: 1 cycle after the last output handshake.

## Test plan
Benches use `N`=8, `ADDR_WIDTH`=3, `ID_COUNTER_WIDTH`=3, with behavioural calculator and partial-sum stubs.

- **Reset values:** assert `reset_n`=0 for 3 cycles → `state`=1; `busy`, `in_ready`, `out_valid` and `done` are all 0.
- **Input loading with gaps:** `start`, then 8 words 0x10..0x17 with `in_valid` dropped for 2 cycles after word 3 → writes land at addresses 0..7 with the matching data. Entry to LLR_READ occurs exactly 1 cycle after the word 0x17 handshake.
- **Layer iterations:** stub raises `llr_sigle_bit_fin` on the 3rd LLR_CAL_AND_STORE of each bit → `state` sequence per bit is 4,8,4,8,4,8,16. `ps_start` pulses once per bit for ids 0..6. `id_counter_value` increments on `ps_done` only.
- **Partial-sum handshake:** `ps_done` delayed by 5 cycles → `state` holds 16 for 6 cycles and `ps_start` stays a single pulse. A spurious `ps_done` in LLR_READ has no effect.
- **Output backpressure:** out buffer holds 8'b10110010; `out_ready` toggles 1,0,0,1,... → bits are emitted LSB-address-first as 0,1,0,0,1,1,0,1, none duplicated or dropped. `done` pulses 1 cycle after the 8th handshake, then `state`=1.
- **Abort and restart:** `reset_n` pulsed low during PS_UPDATE at id 4 → immediate return to IDLE. A subsequent `start` decodes a full frame with `id_counter_value` starting at 0.

Source files
------------

// File: rtl/polar_decoder_ctrl_if.sv
// Handshake and memory-side bus of the polar decoder sequencer.
// "master" is the controller side; "slave" is the calculator, partial-sum
// unit, BRAMs and the up/downstream stream ports.
interface polar_decoder_ctrl_if #(
    parameter int ADDR_WIDTH       = 10,
    parameter int ID_COUNTER_WIDTH = 10,
    parameter int DATA_WIDTH       = 8,
    parameter int STATE_WIDTH      = 9
);
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        in_valid;
    logic [DATA_WIDTH-1:0]       in_data;
    logic                        in_ready;
    logic [ADDR_WIDTH-1:0]       addr_to_llr_init_bram_wr;
    logic [DATA_WIDTH-1:0]       data_to_llr_init_bram_wr;
    logic                        write_enable_to_llr_init_bram;
    logic [STATE_WIDTH-1:0]      state;
    logic                        llr_sigle_bit_fin;
    logic                        llr_cal_fin;
    logic [ID_COUNTER_WIDTH-1:0] id_counter_value;
    logic                        ps_start;
    logic                        ps_done;
    logic [ADDR_WIDTH-1:0]       addr_to_out_buffer_bram;
    logic                        enable_to_out_buffer_bram;
    logic                        data_from_out_buffer_bram;
    logic                        out_valid;
    logic                        out_data;
    logic                        out_ready;

    modport master (
        input  start, in_valid, in_data, llr_sigle_bit_fin, llr_cal_fin,
               ps_done, data_from_out_buffer_bram, out_ready,
        output busy, done, in_ready, addr_to_llr_init_bram_wr,
               data_to_llr_init_bram_wr, write_enable_to_llr_init_bram,
               state, id_counter_value, ps_start, addr_to_out_buffer_bram,
               enable_to_out_buffer_bram, out_valid, out_data
    );

    modport slave (
        output start, in_valid, in_data, llr_sigle_bit_fin, llr_cal_fin,
               ps_done, data_from_out_buffer_bram, out_ready,
        input  busy, done, in_ready, addr_to_llr_init_bram_wr,
               data_to_llr_init_bram_wr, write_enable_to_llr_init_bram,
               state, id_counter_value, ps_start, addr_to_out_buffer_bram,
               enable_to_out_buffer_bram, out_valid, out_data
    );
endinterface

// File: rtl/polar_decoder_ctrl.sv
// Top-level sequencer of the successive-cancellation polar decoder.
//
// state             | meaning
// ------------------+-------------------------------------------------
// IDLE      (1)     | waiting for start
// INPUT     (2)     | loading N channel LLRs into the init BRAM
// LLR_READ  (4)     | one-cycle BRAM read latency slot per layer
// LLR_CAL   (8)     | calculator computes/stores one layer
// PS_UPDATE (16)    | partial-sum update for the current bit
// OUTPUT    (32)    | stream decoded bits out of the output buffer
// DONE      (64)    | one-cycle frame-end pulse
//
// Any other encoding falls back to IDLE on the next edge.
module polar_decoder_ctrl #(
    parameter int N                = 1024,
    parameter int ADDR_WIDTH       = 10,
    parameter int ID_COUNTER_WIDTH = 10,
    parameter int DATA_WIDTH       = 8,
    parameter int STATE_WIDTH      = 9
) (
    input  logic clk,
    input  logic reset_n,
    polar_decoder_ctrl_if.master bus
);

    typedef enum logic [8:0] {
        S_IDLE      = 9'd1,
        S_INPUT     = 9'd2,
        S_LLR_READ  = 9'd4,
        S_LLR_CAL   = 9'd8,
        S_PS_UPDATE = 9'd16,
        S_OUTPUT    = 9'd32,
        S_DONE      = 9'd64
    } state_t;

    // Terminal count compared against N-1 so N = 2^ADDR_WIDTH never overflows.
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);

    state_t                      r_state;
    state_t                      w_next;
    logic [ADDR_WIDTH-1:0]       r_in_cnt;
    logic [ADDR_WIDTH-1:0]       r_out_cnt;
    logic [ID_COUNTER_WIDTH-1:0] r_id_cnt;
    logic                        r_primed;
    logic                        r_ps_start;
    logic                        r_done;

    logic                        w_in_hs;
    logic                        w_out_valid;
    logic                        w_fire;
    logic                        w_bit_fin;
    logic [DATA_WIDTH-1:0]       w_llr_word;

    assign w_in_hs     = (r_state == S_INPUT) & bus.in_valid;
    // primed lags OUTPUT entry by a cycle to cover the buffer read latency.
    assign w_out_valid = r_primed & (r_state == S_OUTPUT);
    assign w_fire      = w_out_valid & bus.out_ready;
    assign w_bit_fin   = (r_state == S_LLR_CAL) & bus.llr_sigle_bit_fin;
    assign w_llr_word  = bus.in_data;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:      w_next = bus.start ? S_INPUT : S_IDLE;
            S_INPUT:     w_next = (w_in_hs && (r_in_cnt == LAST)) ? S_LLR_READ : S_INPUT;
            S_LLR_READ:  w_next = S_LLR_CAL;
            S_LLR_CAL: begin
                if (!bus.llr_sigle_bit_fin) begin
                    w_next = S_LLR_READ;
                end else if (bus.llr_cal_fin) begin
                    w_next = S_OUTPUT;
                end else begin
                    w_next = S_PS_UPDATE;
                end
            end
            S_PS_UPDATE: w_next = bus.ps_done ? S_LLR_READ : S_PS_UPDATE;
            S_OUTPUT:    w_next = (w_fire && (r_out_cnt == LAST)) ? S_DONE : S_OUTPUT;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Counters, the primed flag and the registered pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_id_cnt   <= '0;
            r_primed   <= 1'b0;
            r_ps_start <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ps_start <= w_bit_fin & ~bus.llr_cal_fin;
            r_done     <= w_fire & (r_out_cnt == LAST);
            r_primed   <= (r_state == S_OUTPUT);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_id_cnt  <= '0;
                        r_primed  <= 1'b0;
                    end
                end
                S_INPUT: begin
                    if (w_in_hs) begin
                        r_in_cnt <= r_in_cnt + ADDR_WIDTH'(1);
                    end
                end
                S_PS_UPDATE: begin
                    if (bus.ps_done) begin
                        r_id_cnt <= r_id_cnt + ID_COUNTER_WIDTH'(1);
                    end
                end
                S_OUTPUT: begin
                    if (w_fire) begin
                        r_out_cnt <= r_out_cnt + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.state                         = STATE_WIDTH'(r_state);
    assign bus.busy                          = (r_state != S_IDLE);
    assign bus.done                          = r_done;
    assign bus.in_ready                      = (r_state == S_INPUT);
    assign bus.addr_to_llr_init_bram_wr      = r_in_cnt;
    assign bus.data_to_llr_init_bram_wr      = w_llr_word;
    assign bus.write_enable_to_llr_init_bram = w_in_hs;
    assign bus.id_counter_value              = r_id_cnt;
    assign bus.ps_start                      = r_ps_start;
    // Look one address ahead on a handshake so the next bit lands next cycle.
    assign bus.addr_to_out_buffer_bram       = w_fire ? (r_out_cnt + ADDR_WIDTH'(1)) : r_out_cnt;
    assign bus.enable_to_out_buffer_bram     = (r_state == S_OUTPUT);
    assign bus.out_valid                     = w_out_valid;
    assign bus.out_data                      = bus.data_from_out_buffer_bram;

endmodule

// File: tb/tb_polar_decoder_ctrl.sv
// Directed bench for polar_decoder_ctrl with calculator, partial-sum and
// output-buffer stubs, N = 8.
module tb_polar_decoder_ctrl;
    localparam int N = 8, AW = 3, IW = 3, DW = 8, SW = 9;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    polar_decoder_ctrl_if #(.ADDR_WIDTH(AW), .ID_COUNTER_WIDTH(IW),
                            .DATA_WIDTH(DW), .STATE_WIDTH(SW)) bus ();

    polar_decoder_ctrl #(.N(N), .ADDR_WIDTH(AW), .ID_COUNTER_WIDTH(IW),
                         .DATA_WIDTH(DW), .STATE_WIDTH(SW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fire_cnt = 0;
    int last_fire_cyc = 0;

    logic [31:0] wr_q[$];
    logic [31:0] out_q[$];
    logic [31:0] trace_q[$];
    logic [31:0] exp_tr[$];
    logic [31:0] id_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Calculator stub: bit finishes on the 3rd LLR_CAL of each bit.
    logic [1:0] cal_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cal_cnt <= 2'd0;
        else if (bus.state == 9'd8) cal_cnt <= (cal_cnt == 2'd2) ? 2'd0 : cal_cnt + 2'd1;
    end
    assign bus.llr_sigle_bit_fin = (bus.state == 9'd8) && (cal_cnt == 2'd2);
    assign bus.llr_cal_fin = bus.llr_sigle_bit_fin && (bus.id_counter_value == 3'd7);

    // Partial-sum stub: per-bit ps_done delay after ps_start.
    function automatic int ps_delay(input logic [2:0] id);
        return (id == 3'd2) ? 5 : ((id == 3'd1) ? 0 : 1);
    endfunction
    int ps_cnt;
    logic ps_pend;
    logic spur;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_pend <= 1'b0;
            ps_cnt <= 0;
        end else if (bus.ps_start && ps_delay(bus.id_counter_value) > 0) begin
            ps_pend <= 1'b1;
            ps_cnt <= ps_delay(bus.id_counter_value) - 1;
        end else if (ps_pend) begin
            if (ps_cnt == 0) ps_pend <= 1'b0;
            else ps_cnt <= ps_cnt - 1;
        end
    end
    // Spurious ps_done during the second LLR_READ of bit 3.
    assign spur = (bus.state == 9'd4) && (bus.id_counter_value == 3'd3) && (cal_cnt == 2'd1);
    assign bus.ps_done = (bus.ps_start && ps_delay(bus.id_counter_value) == 0)
                       || (ps_pend && ps_cnt == 0) || spur;

    // Output buffer with 1-cycle read latency; out_ready pattern 1,0,0,...
    logic [7:0] obuf = 8'b10110010;
    logic obuf_rd = 1'b0;
    logic [1:0] rc = 2'd0;
    always @(posedge clk) if (bus.enable_to_out_buffer_bram) obuf_rd <= obuf[bus.addr_to_out_buffer_bram];
    always @(posedge clk) rc <= (rc == 2'd2) ? 2'd0 : rc + 2'd1;
    assign bus.data_from_out_buffer_bram = obuf_rd;
    assign bus.out_ready = (rc == 2'd0);

    // Monitors: scoreboard pops and state/ps_start trace capture.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.write_enable_to_llr_init_bram) begin
                if (wr_q.size() == 0) chk("wr_unexpected", wr_q.size(), 1);
                else chk("wr_addr_data", 32'({bus.addr_to_llr_init_bram_wr, bus.data_to_llr_init_bram_wr}), wr_q.pop_front());
            end
            if (bus.out_valid && bus.out_ready) begin
                if (out_q.size() == 0) chk("out_unexpected", out_q.size(), 1);
                else chk("out_bit", 32'(bus.out_data), out_q.pop_front());
                fire_cnt++;
                last_fire_cyc = cyc;
            end
            if (bus.state == 9'd4 || bus.state == 9'd8 || bus.state == 9'd16)
                trace_q.push_back(32'(bus.state));
            if (bus.ps_start) id_q.push_back(32'(bus.id_counter_value));
        end
    end

    task automatic build_exp_trace();
        exp_tr.delete();
        for (int id = 0; id < 8; id++) begin
            for (int l = 0; l < 3; l++) begin
                exp_tr.push_back(32'd4);
                exp_tr.push_back(32'd8);
            end
            if (id < 7) for (int k = 0; k <= ps_delay(3'(id)); k++) exp_tr.push_back(32'd16);
        end
    endtask

    task automatic start_and_load(input logic [7:0] base, input bit gap);
        trace_q.delete();
        id_q.delete();
        fire_cnt = 0;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        chk("start_to_in_ready", 32'(bus.in_ready), 1);
        chk("state_input", 32'(bus.state), 2);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = base + 8'(i);
            wr_q.push_back(32'(i * 256 + int'(base) + i));
            @(posedge clk); #1 bus.in_valid = 1'b0;
            if (gap && i == 3) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
        chk("llr_read_entry", 32'(bus.state), 4);
        chk("in_ready_low", 32'(bus.in_ready), 0);
        chk("wr_q_drained", 32'(wr_q.size()), 0);
        chk("id_start", 32'(bus.id_counter_value), 0);
    endtask

    task automatic finish_frame();
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) out_q.push_back(32'(obuf[i]));
        while (bus.done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(bus.done), 1);
        chk("done_latency", 32'(cyc - last_fire_cyc), 1);
        chk("fire_count", 32'(fire_cnt), 8);
        chk("state_done", 32'(bus.state), 64);
        chk("out_q_drained", 32'(out_q.size()), 0);
        @(negedge clk);
        chk("state_idle_after_done", 32'(bus.state), 1);
        chk("done_single", 32'(bus.done), 0);
        build_exp_trace();
        chk("trace_len", 32'(trace_q.size()), 32'(exp_tr.size()));
        for (int i = 0; i < trace_q.size() && i < exp_tr.size(); i++)
            chk($sformatf("trace_%0d", i), trace_q[i], exp_tr[i]);
        chk("ps_start_count", 32'(id_q.size()), 7);
        for (int i = 0; i < id_q.size() && i < 7; i++)
            chk($sformatf("ps_start_id_%0d", i), id_q[i], 32'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(bus.state), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_id", 32'(bus.id_counter_value), 0);
        reset_n = 1'b1;

        // Frame 1: input gaps, full decode with backpressured output.
        start_and_load(8'h10, 1'b1);
        finish_frame();

        // Frame 2: abort during PS_UPDATE at id 4.
        start_and_load(8'h20, 1'b0);
        n = 0;
        while (!(bus.state == 9'd16 && bus.id_counter_value == 3'd4) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_ps_id4", 32'(bus.state), 16);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_state", 32'(bus.state), 1);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_id", 32'(bus.id_counter_value), 0);
        chk("abort_ps_start", 32'(bus.ps_start), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_without_start", 32'(bus.state), 1);

        // Frame 3: full decode after the abort.
        start_and_load(8'h30, 1'b0);
        finish_frame();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
